// File: rtl/ssd_capture_pkg.sv
// Shared constants and types for seven-segment scan capture.
// Segment patterns are active-low, ordered g,f,e,d,c,b,a.
package ssd_capture_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] CODE_BLANK   = 4'hE;
    localparam logic [3:0] CODE_ILLEGAL = 4'hF;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StLocked
    } scan_state_t;

endpackage

// File: rtl/ssd_pattern_decode.sv
// Combinational segment-pattern to digit-code lookup.
module ssd_pattern_decode
    import ssd_capture_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] code,
    output logic       illegal
);

    always_comb begin
        illegal = 1'b0;
        unique case (seg)
            SEG_0:     code = 4'd0;
            SEG_1:     code = 4'd1;
            SEG_2:     code = 4'd2;
            SEG_3:     code = 4'd3;
            SEG_4:     code = 4'd4;
            SEG_5:     code = 4'd5;
            SEG_6:     code = 4'd6;
            SEG_7:     code = 4'd7;
            SEG_8:     code = 4'd8;
            SEG_9:     code = 4'd9;
            SEG_BLANK: code = CODE_BLANK;
            default: begin
                code    = CODE_ILLEGAL;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ssd_scan_capture.sv
// Captures a multiplexed 4-digit seven-segment display into decoded frames
// with a valid/ready handshake.
module ssd_scan_capture
    import ssd_capture_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] basys_anode,
    input  logic [6:0] display_ssd,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic       frame_valid,
    input  logic       frame_ready,
    output logic       overrun,
    output logic       pattern_err
);

    // Counter value seen on the edge carrying the STABLE_CYCLES-th identical sample.
    localparam logic [7:0] ACCEPT_CNT = 8'(STABLE_CYCLES - 2);

    logic [10:0] sync_q [SYNC_STAGES];
    logic [10:0] sample;
    logic [10:0] prev_q;
    logic [3:0]  anode_s;
    logic [6:0]  seg_s;
    logic        changed;
    logic        anode_ok;
    logic [1:0]  idx;
    logic [3:0]  code;
    logic        illegal;
    logic        accept;

    scan_state_t state_q;
    logic [7:0]  cnt_q;
    logic [3:0]  shadow_q [4];
    logic [3:0]  seen_q;

    // Reset to all ones so a blank, deselected display is the idle sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '1;
        end else begin
            sync_q[0] <= {basys_anode, display_ssd};
            for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sample  = sync_q[SYNC_STAGES-1];
    assign anode_s = sample[10:7];
    assign seg_s   = sample[6:0];
    assign changed = (sample != prev_q);

    always_comb begin
        anode_ok = 1'b1;
        idx      = 2'd0;
        case (anode_s)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: anode_ok = 1'b0;
        endcase
    end

    ssd_pattern_decode u_decode (
        .seg     (seg_s),
        .code    (code),
        .illegal (illegal)
    );

    assign accept = (state_q == StSettle) && anode_ok && !changed && (cnt_q == ACCEPT_CNT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            prev_q  <= '1;
        end else begin
            prev_q <= sample;
            if (!anode_ok) begin
                state_q <= StIdle;
                cnt_q   <= '0;
            end else if (changed) begin
                state_q <= StSettle;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    StIdle: begin
                        state_q <= StSettle;
                        cnt_q   <= '0;
                    end
                    StSettle: begin
                        if (cnt_q == ACCEPT_CNT) state_q <= StLocked;
                        cnt_q <= cnt_q + 8'd1;
                    end
                    StLocked: begin
                        if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
                    end
                    default: begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) shadow_q[i] <= CODE_BLANK;
            seen_q      <= '0;
            digit0      <= CODE_BLANK;
            digit1      <= CODE_BLANK;
            digit2      <= CODE_BLANK;
            digit3      <= CODE_BLANK;
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
            pattern_err <= 1'b0;
        end else begin
            if (seen_q == 4'hF) begin
                seen_q <= '0;
                if (!frame_valid || frame_ready) begin
                    digit0      <= shadow_q[0];
                    digit1      <= shadow_q[1];
                    digit2      <= shadow_q[2];
                    digit3      <= shadow_q[3];
                    frame_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end
            // Placed last so a same-cycle accept keeps its seen bit.
            if (accept) begin
                shadow_q[idx] <= code;
                seen_q[idx]   <= 1'b1;
                if (illegal) pattern_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ssd_scan_capture.sv
// Scoreboard bench for ssd_scan_capture: expected frames queued per scan,
// observed frames captured on each rising frame_valid.
module tb_ssd_scan_capture;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] basys_anode = 4'hF;
    logic [6:0] display_ssd = 7'h7F;
    logic       frame_ready = 1'b0;
    logic [3:0] digit0, digit1, digit2, digit3;
    logic       frame_valid, overrun, pattern_err;

    localparam logic [6:0] SEG_TAB [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_q [$];
    logic [15:0] obs_q [$];
    logic        fv_prev = 1'b0;

    always #5 clk = ~clk;

    ssd_scan_capture dut (
        .clk         (clk),
        .reset       (reset),
        .basys_anode (basys_anode),
        .display_ssd (display_ssd),
        .digit0      (digit0),
        .digit1      (digit1),
        .digit2      (digit2),
        .digit3      (digit3),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .overrun     (overrun),
        .pattern_err (pattern_err)
    );

    always @(negedge clk) begin
        if (frame_valid && !fv_prev) obs_q.push_back({digit3, digit2, digit1, digit0});
        fv_prev = frame_valid;
    end

    task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
        basys_anode = an;
        display_ssd = seg;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input logic [6:0] s0, input logic [6:0] s1,
                        input logic [6:0] s2, input logic [6:0] s3);
        hold(4'b1110, s0, 40);
        hold(4'b1101, s1, 40);
        hold(4'b1011, s2, 40);
        hold(4'b0111, s3, 40);
        hold(4'b1111, 7'h7F, 10);
    endtask

    task automatic wait_frames(input int n);
        for (int i = 0; i < 200 && obs_q.size() < n; i++) @(negedge clk);
    endtask

    task automatic pulse_reset();
        basys_anode = 4'hF;
        display_ssd = 7'h7F;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [15:0] e, o;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({digit3, digit2, digit1, digit0} !== 16'hEEEE) begin
            n_err++;
            $display("FAIL reset_digits: got %h want eeee", {digit3, digit2, digit1, digit0});
        end
        n_cmp++;
        if ({frame_valid, overrun, pattern_err} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 000", {frame_valid, overrun, pattern_err});
        end
        reset = 1'b1;
        repeat (30) @(negedge clk);
        n_cmp++;
        if (obs_q.size() != 0 || frame_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle_frame: got %0d frames want 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_scan();
        logic [15:0] e, o;
        frame_ready = 1'b1;
        exp_q.push_back(16'h1809);
        scan(SEG_TAB[9], SEG_TAB[0], SEG_TAB[8], SEG_TAB[1]);
        wait_frames(exp_q.size());
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL scan_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL scan_frame: got %h want %h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
        n_cmp++;
        if ({frame_valid, overrun} !== 2'b00) begin
            n_err++;
            $display("FAIL scan_flags: got %b want 00", {frame_valid, overrun});
        end
    endtask

    task automatic test_short_hold();
        logic [15:0] e, o;
        frame_ready = 1'b1;
        hold(4'b1110, SEG_TAB[3], 15);
        hold(4'b1111, 7'h7F, 20);
        hold(4'b1101, SEG_TAB[4], 40);
        hold(4'b1011, SEG_TAB[5], 40);
        hold(4'b0111, SEG_TAB[6], 40);
        hold(4'b1111, 7'h7F, 20);
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_err++;
            $display("FAIL short_hold_no_frame: got %0d frames want 0", obs_q.size());
        end
        exp_q.push_back(16'h6547);
        hold(4'b1110, SEG_TAB[7], 40);
        hold(4'b1111, 7'h7F, 10);
        wait_frames(exp_q.size());
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL short_hold_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL short_hold_frame: got %h want %h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_overrun();
        logic [15:0] e, o;
        frame_ready = 1'b0;
        exp_q.push_back(16'h2345);
        scan(SEG_TAB[5], SEG_TAB[4], SEG_TAB[3], SEG_TAB[2]);
        n_cmp++;
        if ({frame_valid, overrun} !== 2'b10) begin
            n_err++;
            $display("FAIL overrun_first: got %b want 10", {frame_valid, overrun});
        end
        scan(SEG_TAB[9], SEG_TAB[9], SEG_TAB[9], SEG_TAB[9]);
        n_cmp++;
        if ({digit3, digit2, digit1, digit0} !== 16'h2345) begin
            n_err++;
            $display("FAIL overrun_held: got %h want 2345", {digit3, digit2, digit1, digit0});
        end
        n_cmp++;
        if ({frame_valid, overrun} !== 2'b11) begin
            n_err++;
            $display("FAIL overrun_flag: got %b want 11", {frame_valid, overrun});
        end
        frame_ready = 1'b1;
        @(negedge clk);
        frame_ready = 1'b0;
        n_cmp++;
        if (frame_valid !== 1'b0) begin
            n_err++;
            $display("FAIL overrun_release: got %b want 0", frame_valid);
        end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL overrun_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL overrun_frame: got %h want %h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_pattern();
        logic [15:0] e, o;
        pulse_reset();
        frame_ready = 1'b1;
        exp_q.push_back(16'h3F21);
        scan(SEG_TAB[1], SEG_TAB[2], 7'b1010101, SEG_TAB[3]);
        n_cmp++;
        if (pattern_err !== 1'b1) begin
            n_err++;
            $display("FAIL pattern_err_set: got %b want 1", pattern_err);
        end
        exp_q.push_back(16'h3E21);
        scan(SEG_TAB[1], SEG_TAB[2], 7'h7F, SEG_TAB[3]);
        n_cmp++;
        if (pattern_err !== 1'b1) begin
            n_err++;
            $display("FAIL pattern_err_sticky: got %b want 1", pattern_err);
        end
        wait_frames(exp_q.size());
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL pattern_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL pattern_frame: got %h want %h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_idle();
        logic [15:0] e, o;
        frame_ready = 1'b1;
        hold(4'b1110, SEG_TAB[4], 40);
        hold(4'b1101, SEG_TAB[5], 40);
        hold(4'b1011, SEG_TAB[6], 40);
        hold(4'b1100, SEG_TAB[8], 50);
        hold(4'b1111, SEG_TAB[8], 50);
        n_cmp++;
        if (obs_q.size() != 0 || frame_valid !== 1'b0) begin
            n_err++;
            $display("FAIL idle_no_frame: got %0d frames want 0", obs_q.size());
        end
        exp_q.push_back(16'h7654);
        hold(4'b0111, SEG_TAB[7], 40);
        hold(4'b1111, 7'h7F, 10);
        wait_frames(exp_q.size());
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL idle_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL idle_frame: got %h want %h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset_mid();
        logic [15:0] e, o;
        frame_ready = 1'b0;
        exp_q.push_back(16'h0123);
        scan(SEG_TAB[3], SEG_TAB[2], SEG_TAB[1], SEG_TAB[0]);
        n_cmp++;
        if (frame_valid !== 1'b1) begin
            n_err++;
            $display("FAIL mid_pending: got %b want 1", frame_valid);
        end
        hold(4'b1110, SEG_TAB[8], 40);
        hold(4'b1101, SEG_TAB[8], 40);
        hold(4'b1011, SEG_TAB[8], 40);
        hold(4'b0111, SEG_TAB[8], 5);
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({digit3, digit2, digit1, digit0} !== 16'hEEEE) begin
            n_err++;
            $display("FAIL mid_reset_digits: got %h want eeee", {digit3, digit2, digit1, digit0});
        end
        n_cmp++;
        if ({frame_valid, overrun, pattern_err} !== 3'b000) begin
            n_err++;
            $display("FAIL mid_reset_flags: got %b want 000", {frame_valid, overrun, pattern_err});
        end
        basys_anode = 4'hF;
        display_ssd = 7'h7F;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        frame_ready = 1'b1;
        exp_q.push_back(16'h4966);
        scan(SEG_TAB[6], SEG_TAB[6], SEG_TAB[9], SEG_TAB[4]);
        wait_frames(exp_q.size());
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL mid_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL mid_frame: got %h want %h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_scan();
        test_short_hold();
        test_overrun();
        test_pattern();
        test_idle();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
